// File: rtl/pwm_adc_pkg.sv
// rtl/pwm_adc_pkg.sv - shared types and helpers for the PWM-DAC converter
package pwm_adc_pkg;

  typedef enum logic {MODE_RAMP, MODE_SAR} conv_mode_e;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DECIDE, DONE} chan_state_e;

  function automatic int full_scale(input int nbits);
    return (1 << nbits) - 1;
  endfunction

  // Period equals full-scale so a full-scale duty is a constant high level.
  function automatic int pwm_period(input int nbits);
    return (1 << nbits) - 1;
  endfunction

endpackage

// File: rtl/pwm_adc_chan.sv
// rtl/pwm_adc_chan.sv - one converter channel: cmp synchroniser, PWM, ramp/SAR FSM, result.
// PWM_ADC_AVG_EN defined: four back-to-back conversions are averaged into each result.
module pwm_adc_chan
  import pwm_adc_pkg::*;
#(
  parameter int               NBITS          = 6,
  parameter int               SETTLE_PERIODS = 8,
  parameter logic [NBITS-1:0] ResetValue     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             reverse_i,
  input  logic [NBITS-1:0] step_i,
  input  logic             cmp_i,
  input  logic             adc_ready_i,
  output logic             pwm_o,
  output logic [NBITS-1:0] adc_value_o,
  output logic             adc_valid_o,
  output logic             busy_o
);

  localparam logic [NBITS-1:0] FS    = NBITS'(full_scale(NBITS));
  localparam logic [NBITS-1:0] LAST  = NBITS'(pwm_period(NBITS) - 1);
  localparam logic [NBITS-1:0] MSB   = {1'b1, {(NBITS-1){1'b0}}};
  localparam int               SW    = $clog2(SETTLE_PERIODS + 1);
  localparam logic [SW-1:0]    SLAST = SW'(SETTLE_PERIODS);

  chan_state_e      state_q, state_d;
  conv_mode_e       mode_q, mode_d;
  logic             rev_q, rev_d;
  logic [NBITS-1:0] step_q, step_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] bit_q, bit_d;
  logic [NBITS-1:0] trial_q, trial_d;
  logic [NBITS-1:0] duty_q;
  logic [NBITS-1:0] value_q, value_d;
  logic [NBITS-1:0] cnt_q;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       sync_q;
  logic             cmp, wrap, busy, fin;
  logic [NBITS-1:0] res;
`ifdef PWM_ADC_AVG_EN
  logic [NBITS+1:0] acc_q, acc_d, sum_w;
  logic [1:0]       nconv_q, nconv_d;
  logic [NBITS+2:0] avg_w;
`endif

  assign cmp  = sync_q[1];
  assign wrap = (cnt_q == LAST);
  assign busy = (state_q == LOAD) || (state_q == SETTLE) || (state_q == DECIDE);

  assign pwm_o       = (state_q != IDLE) && (cnt_q < duty_q);
  assign busy_o      = busy;
  assign adc_valid_o = (state_q == DONE);
  assign adc_value_o = value_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mode_q   <= MODE_RAMP;
      rev_q    <= 1'b0;
      step_q   <= '0;
      code_q   <= ResetValue;
      bit_q    <= '0;
      trial_q  <= ResetValue;
      duty_q   <= ResetValue;
      value_q  <= ResetValue;
      cnt_q    <= '0;
      settle_q <= '0;
      sync_q   <= '0;
`ifdef PWM_ADC_AVG_EN
      acc_q    <= '0;
      nconv_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rev_q    <= rev_d;
      step_q   <= step_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      trial_q  <= trial_d;
      value_q  <= value_d;
      settle_q <= settle_d;
      sync_q   <= {sync_q[0], cmp_i};
      cnt_q    <= wrap ? '0 : cnt_q + NBITS'(1);
      // New duty only lands on a period boundary, so no runt pulses.
      if (wrap) duty_q <= trial_q;
`ifdef PWM_ADC_AVG_EN
      acc_q    <= acc_d;
      nconv_q  <= nconv_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rev_d    = rev_q;
    step_d   = step_q;
    code_d   = code_q;
    bit_d    = bit_q;
    trial_d  = trial_q;
    settle_d = settle_q;
    value_d  = value_q;
    fin      = 1'b0;
    res      = '0;
    case (state_q)
      IDLE: begin
        trial_d = ResetValue;
        if (enable_i) begin
          mode_d  = mode_i ? MODE_SAR : MODE_RAMP;
          rev_d   = reverse_i;
          step_d  = (step_i == '0) ? NBITS'(1) : step_i;
          code_d  = (!mode_i && reverse_i) ? FS : '0;
          bit_d   = MSB;
          state_d = LOAD;
        end
      end
      LOAD: begin
        trial_d  = (mode_q == MODE_SAR) ? (code_q | bit_q) : code_q;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        // First wrap applies the duty; the following SETTLE_PERIODS wraps are the settling time.
        if (wrap) begin
          if (settle_q == SLAST) state_d = DECIDE;
          else settle_d = settle_q + SW'(1);
        end
      end
      DECIDE: begin
        state_d = LOAD;
        if (mode_q == MODE_SAR) begin
          if (!cmp) code_d = code_q | bit_q;
          if (bit_q[0]) begin
            fin = 1'b1;
            res = cmp ? code_q : (code_q | bit_q);
          end else begin
            bit_d = bit_q >> 1;
          end
        end else if (!rev_q) begin
          if (cmp) begin
            fin = 1'b1;
            res = (code_q >= step_q) ? code_q - step_q : '0;
          end else if (code_q == FS) begin
            fin = 1'b1;
            res = FS;
          end else begin
            code_d = ((FS - code_q) <= step_q) ? FS : code_q + step_q;
          end
        end else begin
          if (!cmp) begin
            fin = 1'b1;
            res = code_q;
          end else if (code_q == '0) begin
            fin = 1'b1;
            res = '0;
          end else begin
            code_d = (code_q > step_q) ? code_q - step_q : '0;
          end
        end
      end
      DONE: begin
        if (adc_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PWM_ADC_AVG_EN
    acc_d   = acc_q;
    nconv_d = nconv_q;
    sum_w   = acc_q + {2'b00, res};
    avg_w   = ({1'b0, sum_w} + (NBITS+3)'(2)) >> 2;
    if (fin) begin
      if (nconv_q == 2'd3) begin
        value_d = (avg_w > {3'b000, FS}) ? FS : avg_w[NBITS-1:0];
        acc_d   = '0;
        nconv_d = '0;
        state_d = DONE;
      end else begin
        acc_d   = sum_w;
        nconv_d = nconv_q + 2'd1;
        code_d  = (mode_q == MODE_RAMP && rev_q) ? FS : '0;
        bit_d   = MSB;
      end
    end
    if (!enable_i && busy) begin
      acc_d   = '0;
      nconv_d = '0;
    end
`else
    if (fin) begin
      value_d = res;
      state_d = DONE;
    end
`endif

    // Abort drops the conversion; a result already in DONE stays until accepted.
    if (!enable_i && busy) state_d = IDLE;
  end

endmodule

// File: rtl/pwm_adc_mc.sv
// rtl/pwm_adc_mc.sv - NCH independent PWM-DAC converter channels with packed outputs.
// PWM_ADC_AVG_EN selects per-channel four-conversion averaging inside pwm_adc_chan.
module pwm_adc_mc
  import pwm_adc_pkg::*;
#(
  parameter int               NBITS          = 6,
  parameter int               NCH            = 4,
  parameter int               SETTLE_PERIODS = 8,
  parameter logic [NBITS-1:0] ResetValue     = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       enable_i,
  input  logic                 mode_i,
  input  logic                 reverse_i,
  input  logic [NBITS-1:0]     step_i,
  input  logic [NCH-1:0]       cmp_i,
  input  logic [NCH-1:0]       adc_ready_i,
  output logic [NCH-1:0]       pwm_o,
  output logic [NCH*NBITS-1:0] adc_value_o,
  output logic [NCH-1:0]       adc_valid_o,
  output logic [NCH-1:0]       busy_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pwm_adc_chan #(
      .NBITS          (NBITS),
      .SETTLE_PERIODS (SETTLE_PERIODS),
      .ResetValue     (ResetValue)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i[c]),
      .mode_i      (mode_i),
      .reverse_i   (reverse_i),
      .step_i      (step_i),
      .cmp_i       (cmp_i[c]),
      .adc_ready_i (adc_ready_i[c]),
      .pwm_o       (pwm_o[c]),
      .adc_value_o (adc_value_o[c*NBITS +: NBITS]),
      .adc_valid_o (adc_valid_o[c]),
      .busy_o      (busy_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_adc_mc.sv
// tb/tb_pwm_adc_mc.sv - directed and randomized checks of pwm_adc_mc against an ideal comparator.
module tb_pwm_adc_mc;
  localparam int NB  = 6;
  localparam int NCH = 4;
  localparam int PER = 63;
  localparam int BUDGET = 30000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    enable_i, cmp_i, adc_ready_i;
  logic              mode_i, reverse_i;
  logic [NB-1:0]     step_i;
  logic [NCH-1:0]    pwm_o, adc_valid_o, busy_o;
  logic [NCH*NB-1:0] adc_value_o;

  int total = 0;
  int bad   = 0;
  int kval [NCH];
  int wsum [NCH];
  bit hist [NCH][PER];
  int wptr = 0;

  pwm_adc_mc #(.NBITS(NB), .NCH(NCH), .SETTLE_PERIODS(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .reverse_i(reverse_i), .step_i(step_i), .cmp_i(cmp_i),
    .adc_ready_i(adc_ready_i), .pwm_o(pwm_o), .adc_value_o(adc_value_o),
    .adc_valid_o(adc_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // RC filter as a one-period moving average of pwm_o; comparator trips at filtered >= K.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      wsum[c] = wsum[c] + int'(pwm_o[c]) - int'(hist[c][wptr]);
      hist[c][wptr] = pwm_o[c];
      cmp_i[c] = (wsum[c] >= kval[c]);
    end
    wptr = (wptr == PER - 1) ? 0 : wptr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_conv(input int m, input int r, input int s, input int k);
    int code;
    int st;
    st = (s == 0) ? 1 : s;
    if (m == 1) return (k <= 0) ? 0 : (k > PER) ? PER : k - 1;
    if (r == 0) begin
      code = 0;
      forever begin
        if (code >= k) return (code - st < 0) ? 0 : code - st;
        if (code == PER) return PER;
        code = (code + st > PER) ? PER : code + st;
      end
    end
    code = PER;
    forever begin
      if (code < k) return code;
      if (code == 0) return 0;
      code = (code - st < 0) ? 0 : code - st;
    end
  endfunction

  function automatic logic [31:0] val(input int c);
    return 32'(adc_value_o[c*NB +: NB]);
  endfunction

  task automatic wait_valid(input int c, input string tag);
    int n = 0;
    while (!adc_valid_o[c] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 32'(adc_valid_o[c]), 32'd1);
  endtask

  task automatic run_conv(input int c, input int m, input int r, input int s,
                          input int k, input int expv, input string tag);
    @(negedge clk);
    mode_i = m[0]; reverse_i = r[0]; step_i = NB'(s); kval[c] = k;
    adc_ready_i[c] = 1'b0; enable_i[c] = 1'b1;
    wait_valid(c, tag);
    check({tag, "_value"}, val(c), 32'(expv));
    check({tag, "_busy_at_valid"}, 32'(busy_o[c]), 32'd0);
    enable_i[c] = 1'b0; adc_ready_i[c] = 1'b1;
    @(negedge clk);
    adc_ready_i[c] = 1'b0;
    check({tag, "_valid_after_accept"}, 32'(adc_valid_o[c]), 32'd0);
  endtask

  initial begin
    int v, seen, m, r, s, k, c;
    bit held;
    rst_i = 1'b1; enable_i = '0; adc_ready_i = '0;
    mode_i = 1'b0; reverse_i = 1'b0; step_i = '0;
    for (int i = 0; i < NCH; i++) kval[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_o), 32'd0);
    check("rst_valid", 32'(adc_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_value", 32'(adc_value_o), 32'd0);
    rst_i = 1'b0;

    // SAR continuous with ready high: single-cycle valid pulses, value 36.
    mode_i = 1'b1; kval[0] = 37; adc_ready_i[0] = 1'b1; enable_i[0] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      wait_valid(0, "sar_cont");
      check("sar_cont_value", val(0), 32'd36);
      check("sar_cont_busy", 32'(busy_o[0]), 32'd0);
      @(negedge clk);
      check("sar_cont_pulse_width", 32'(adc_valid_o[0]), 32'd0);
    end
    enable_i[0] = 1'b0; adc_ready_i[0] = 1'b0;
    repeat (2) @(negedge clk);

    run_conv(0, 0, 0, 1, 37, 36, "up_s1");
    run_conv(1, 0, 0, 4, 37, 36, "up_s4");
    run_conv(2, 0, 0, 0, 37, 36, "up_s0");
    run_conv(3, 0, 1, 1, 37, 36, "dn_s1");
    run_conv(0, 0, 1, 1, 0, 0, "dn_sat0");
    run_conv(1, 0, 0, 1, 64, 63, "up_satfs");

    // Back-pressure: result held 500 clk, no restart until accepted.
    @(negedge clk);
    mode_i = 1'b1; kval[0] = 20; adc_ready_i[0] = 1'b0; enable_i[0] = 1'b1;
    wait_valid(0, "hold");
    v = int'(val(0));
    held = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (!adc_valid_o[0] || busy_o[0] || int'(val(0)) != v) held = 1'b0;
    end
    check("hold_stable", 32'(held), 32'd1);
    check("hold_value", 32'(v), 32'd19);
    adc_ready_i[0] = 1'b1;
    @(negedge clk);
    adc_ready_i[0] = 1'b0;
    check("hold_released", 32'(adc_valid_o[0]), 32'd0);
    @(negedge clk);
    check("hold_restart", 32'(busy_o[0]), 32'd1);
    enable_i[0] = 1'b0;
    @(negedge clk);
    check("hold_abort_busy", 32'(busy_o[0]), 32'd0);

    // Four channels concurrently in SAR mode.
    kval[0] = 5; kval[1] = 20; kval[2] = 40; kval[3] = 64;
    mode_i = 1'b1; adc_ready_i = '0; enable_i = '1;
    seen = 0;
    while (adc_valid_o != '1 && seen < BUDGET) begin
      @(negedge clk);
      seen++;
    end
    check("multi_all_valid", 32'(adc_valid_o), 32'hF);
    check("multi_ch0", val(0), 32'd4);
    check("multi_ch1", val(1), 32'd19);
    check("multi_ch2", val(2), 32'd39);
    check("multi_ch3", val(3), 32'd63);
    enable_i = '0; adc_ready_i = '1;
    @(negedge clk);
    adc_ready_i = '0;
    check("multi_accept_all", 32'(adc_valid_o), 32'd0);

    // Abort mid-SAR.
    kval[1] = 30; enable_i[1] = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_busy_before", 32'(busy_o[1]), 32'd1);
    enable_i[1] = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_o[1]), 32'd0);
    check("abort_pwm", 32'(pwm_o[1]), 32'd0);
    seen = 0;
    repeat (1500) begin
      @(negedge clk);
      if (adc_valid_o[1]) seen = 1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Reset mid-conversion.
    enable_i[2] = 1'b1; enable_i[3] = 1'b1;
    repeat (300) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy_o[3:2]), 32'd3);
    rst_i = 1'b1;
    #1;
    check("rst_mid_pwm", 32'(pwm_o), 32'd0);
    check("rst_mid_valid", 32'(adc_valid_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_value", 32'(adc_value_o), 32'd0);
    enable_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Randomized conversions against the reference model.
    for (int it = 0; it < 6; it++) begin
      c = int'($urandom_range(0, NCH - 1));
      m = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 1));
      s = int'($urandom_range(4, 15));
      k = int'($urandom_range(0, 64));
      run_conv(c, m, r, s, k, ref_conv(m, r, s, k), $sformatf("rnd%0d_c%0d_m%0d_r%0d_s%0d_k%0d", it, c, m, r, s, k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
